// File: rtl/rotate_left_seq.sv
// Sequential 32-bit rotate-left, one power-of-two stage per cycle; ROL_SHIFT_MODE_EN adds a zero-fill shift mode.
// Latency: start accepted on E0, out updated and done pulsed after E5; back-to-back every 6 cycles.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted with no idle gap.
module rotate_left_seq (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] in,
   input  logic [4:0]  rotate,
`ifdef ROL_SHIFT_MODE_EN
   input  logic        mode,
`endif
   output logic [31:0] out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [31:0] data;
   logic [4:0]  amt;
   logic [2:0]  step;
`ifdef ROL_SHIFT_MODE_EN
   logic        mode_q;
`endif

   logic [31:0] rol;
   logic [31:0] shl;
   logic        take;
   logic [31:0] nxt;

   // Stage for the current step: rotate/shift by 2^step when that amount bit is set.
   always_comb begin
      rol  = data;
      shl  = data;
      take = 1'b0;
      case (step)
         3'd0: begin rol = {data[30:0], data[31]};    shl = {data[30:0], 1'b0};  take = amt[0]; end
         3'd1: begin rol = {data[29:0], data[31:30]}; shl = {data[29:0], 2'b0};  take = amt[1]; end
         3'd2: begin rol = {data[27:0], data[31:28]}; shl = {data[27:0], 4'b0};  take = amt[2]; end
         3'd3: begin rol = {data[23:0], data[31:24]}; shl = {data[23:0], 8'b0};  take = amt[3]; end
         3'd4: begin rol = {data[15:0], data[31:16]}; shl = {data[15:0], 16'b0}; take = amt[4]; end
         default: begin rol = data; shl = data; take = 1'b0; end
      endcase
`ifdef ROL_SHIFT_MODE_EN
      nxt = take ? (mode_q ? shl : rol) : data;
`else
      nxt = take ? rol : data;
`endif
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         data  <= 32'h0;
         amt   <= 5'h0;
         step  <= 3'h0;
         out   <= 32'h0;
`ifdef ROL_SHIFT_MODE_EN
         mode_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  data  <= in;
                  amt   <= rotate;
                  step  <= 3'h0;
`ifdef ROL_SHIFT_MODE_EN
                  mode_q <= mode;
`endif
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               data <= nxt;
               step <= step + 3'd1;
               if (step == 3'd4) begin
                  out   <= nxt;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
